// File: rtl/div_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_serial_if
//  Description : Request/response bundle for the serial divider.
//                master : drives start/sign/a/b, observes busy/done/results
//                slave  : the divider itself
//  Ports       : start, sign, a, b            (master -> slave)
//                busy, done, q, r,
//                div_by_zero, overflow        (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface div_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, sign, a, b,
    input  busy, done, q, r, div_by_zero, overflow
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, q, r, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/div_serial.sv
`default_nettype none
// ============================================================================
//  Module      : div_serial
//  Description : Multi-cycle non-restoring radix-2 divider, a = b*q + r,
//                signed or unsigned per operation. One quotient bit per
//                clock followed by one restore/sign-fix cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - div_serial_if.slave (start/sign/a/b in,
//                       busy/done/q/r/div_by_zero/overflow out)
//  Revision    : 1.0  initial release
// ============================================================================
module div_serial #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  div_serial_if.slave bus
);

  localparam int               C_CW  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [C_CW-1:0]         cnt_q, cnt_d;
  logic signed [WIDTH:0]   p_q, p_d;        // partial remainder
  logic [WIDTH-1:0]        aq_q, aq_d;      // dividend out at MSB, quotient in at LSB
  logic [WIDTH-1:0]        d_q, d_d;        // divisor magnitude
  logic [WIDTH-1:0]        a_raw_q, a_raw_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    zero_pend_q, zero_pend_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        q_q, q_d;
  logic [WIDTH-1:0]        r_q, r_d;
  logic                    dz_q, dz_d;
  logic                    ovf_q, ovf_d;

  // Two extra bits so 2P+bit +/- D never wraps before the result is known
  // to fit back into WIDTH+1 bits.
  logic signed [WIDTH+1:0] p_shift;
  logic signed [WIDTH+1:0] d_ext;
  logic signed [WIDTH+1:0] p_step;
  logic [WIDTH-1:0]        rem_mag;
  logic [WIDTH-1:0]        quo_fix;
  logic [WIDTH-1:0]        rem_fix;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    aq_d        = aq_q;
    d_d         = d_q;
    a_raw_d     = a_raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_pend_d = zero_pend_q;
    ovf_pend_d  = ovf_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    q_d         = q_q;
    r_d         = r_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    p_shift = {p_q, aq_q[WIDTH-1]};
    d_ext   = {2'b00, d_q};
    p_step  = p_q[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);

    // Final remainder lies in [0, D), so WIDTH-bit modular add is exact.
    rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    quo_fix = neg_quo_q ? -aq_q : aq_q;
    rem_fix = neg_rem_q ? -rem_mag : rem_mag;

    case (state_q)
      S_IDLE: begin
        // The done cycle still belongs to the finishing operation.
        if (bus.start && !done_q) begin
          state_d     = S_CALC;
          busy_d      = 1'b1;
          cnt_d       = C_CW'(WIDTH - 1);
          p_d         = '0;
          aq_d        = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          d_d         = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          a_raw_d     = bus.a;
          neg_quo_d   = bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d   = bus.sign && bus.a[WIDTH-1];
          zero_pend_d = (bus.b == '0);
          ovf_pend_d  = bus.sign && (bus.a == C_MIN) && (bus.b == '1);
          dz_d        = 1'b0;
          ovf_d       = 1'b0;
        end
      end

      S_CALC: begin
        p_d  = p_step[WIDTH:0];
        aq_d = {aq_q[WIDTH-2:0], ~p_step[WIDTH+1]};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - C_CW'(1);
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zero_pend_q) begin
          q_d   = '1;
          r_d   = a_raw_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else if (ovf_pend_q) begin
          q_d   = C_MIN;
          r_d   = '0;
          dz_d  = 1'b0;
          ovf_d = 1'b1;
        end else begin
          q_d   = quo_fix;
          r_d   = rem_fix;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      aq_q        <= '0;
      d_q         <= '0;
      a_raw_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_pend_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      aq_q        <= aq_d;
      d_q         <= d_d;
      a_raw_q     <= a_raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_pend_q <= zero_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_serial
//  Description : Self-checking bench for div_serial. Three instances
//                (WIDTH 2, 8, 13) share clock and reset; directed cases run
//                on the 8-bit instance, randomized operands run on all
//                three in parallel against an integer-arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_start [3];
  logic        drv_sign  [3];
  logic [12:0] drv_a     [3];
  logic [12:0] drv_b     [3];

  logic [12:0] mon_q    [3];
  logic [12:0] mon_r    [3];
  logic        mon_busy [3];
  logic        mon_done [3];
  logic        mon_dz   [3];
  logic        mon_ovf  [3];

  logic [12:0] res_q [3];
  logic [12:0] res_r [3];
  bit          res_dz [3], res_ovf [3], res_seen [3];
  bit          res_busy_acc [3], res_flag_acc [3], res_busy_done [3];
  int          res_lat [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_serial_if #(.WIDTH(2))  if0 ();
  div_serial_if #(.WIDTH(8))  if1 ();
  div_serial_if #(.WIDTH(13)) if2 ();

  div_serial #(.WIDTH(2))  u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  div_serial #(.WIDTH(8))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  div_serial #(.WIDTH(13)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.start = drv_start[0];
  assign if0.sign  = drv_sign[0];
  assign if0.a     = drv_a[0][1:0];
  assign if0.b     = drv_b[0][1:0];
  assign if1.start = drv_start[1];
  assign if1.sign  = drv_sign[1];
  assign if1.a     = drv_a[1][7:0];
  assign if1.b     = drv_b[1][7:0];
  assign if2.start = drv_start[2];
  assign if2.sign  = drv_sign[2];
  assign if2.a     = drv_a[2];
  assign if2.b     = drv_b[2];

  assign mon_q[0] = {11'd0, if0.q};
  assign mon_r[0] = {11'd0, if0.r};
  assign mon_q[1] = {5'd0, if1.q};
  assign mon_r[1] = {5'd0, if1.r};
  assign mon_q[2] = if2.q;
  assign mon_r[2] = if2.r;
  assign mon_busy[0] = if0.busy;  assign mon_done[0] = if0.done;
  assign mon_busy[1] = if1.busy;  assign mon_done[1] = if1.done;
  assign mon_busy[2] = if2.busy;  assign mon_done[2] = if2.done;
  assign mon_dz[0] = if0.div_by_zero;  assign mon_ovf[0] = if0.overflow;
  assign mon_dz[1] = if1.div_by_zero;  assign mon_ovf[1] = if1.overflow;
  assign mon_dz[2] = if2.div_by_zero;  assign mon_ovf[2] = if2.overflow;

  function automatic int width_of(input int i);
    case (i)
      0:       return 2;
      1:       return 8;
      default: return 13;
    endcase
  endfunction

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic void model(input int w, input bit sg,
                                input logic [12:0] a, input logic [12:0] b,
                                output logic [12:0] eq, output logic [12:0] er,
                                output bit edz, output bit eovf);
    longint one, m, sa, sb, qv, rv;
    one  = 1;
    m    = (one << w) - 1;
    edz  = 1'b0;
    eovf = 1'b0;
    sa   = longint'(a);
    sb   = longint'(b);
    if (b == 13'd0) begin
      eq  = 13'(m);
      er  = a;
      edz = 1'b1;
    end else if (sg) begin
      if (a[w-1]) sa = sa - (one << w);
      if (b[w-1]) sb = sb - (one << w);
      if (sa == -(one << (w - 1)) && sb == -1) begin
        eq   = 13'(one << (w - 1));
        er   = 13'd0;
        eovf = 1'b1;
      end else begin
        qv = sa / sb;
        rv = sa % sb;
        eq = 13'(qv & m);
        er = 13'(rv & m);
      end
    end else begin
      eq = 13'((sa / sb) & m);
      er = 13'((sa % sb) & m);
    end
  endfunction

  // Launch one operation on each enabled instance at the earliest legal edge
  // and capture results when each done pulse appears.
  task automatic run_ops(input bit [2:0] en);
    bit all_seen;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) drv_start[i] = en[i];
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drv_start[i]    = 1'b0;
      res_busy_acc[i] = mon_busy[i];
      res_flag_acc[i] = mon_dz[i] | mon_ovf[i];
      res_seen[i]     = 1'b0;
      res_lat[i]      = 0;
    end
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (en[i] && !res_seen[i] && mon_done[i]) begin
          res_seen[i]      = 1'b1;
          res_lat[i]       = c;
          res_q[i]         = mon_q[i];
          res_r[i]         = mon_r[i];
          res_dz[i]        = mon_dz[i];
          res_ovf[i]       = mon_ovf[i];
          res_busy_done[i] = mon_busy[i];
        end
        if (en[i] && !res_seen[i]) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({mon_busy[i], mon_done[i], mon_dz[i], mon_ovf[i], mon_q[i], mon_r[i]} !== 30'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h want all 0",
                 i, mon_busy[i], mon_done[i], mon_dz[i], mon_ovf[i], mon_q[i], mon_r[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    bit         sg;
    logic [7:0] a, b, q, r;
    bit         dz, ovf;
  } dcase_t;

  task automatic test_directed();
    dcase_t dt [7];
    dt[0] = '{"u200/7",   1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0};
    dt[1] = '{"s-7/2",    1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};
    dt[2] = '{"s7/-2",    1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0};
    dt[3] = '{"u35/0",    1'b0, 8'h35, 8'h00, 8'hFF, 8'h35, 1'b1, 1'b0};
    dt[4] = '{"s35/0",    1'b1, 8'h35, 8'h00, 8'hFF, 8'h35, 1'b1, 1'b0};
    dt[5] = '{"s80/FF",   1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
    dt[6] = '{"u80/FF",   1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      drv_sign[1] = dt[k].sg;
      drv_a[1]    = {5'd0, dt[k].a};
      drv_b[1]    = {5'd0, dt[k].b};
      run_ops(3'b010);
      n_vec++;
      if (res_lat[1] !== width_of(1) + 1) begin
        n_err++;
        $display("FAIL %s latency: got %0d want %0d", dt[k].name, res_lat[1], width_of(1) + 1);
      end
      n_vec++;
      if (res_q[1][7:0] !== dt[k].q || res_r[1][7:0] !== dt[k].r) begin
        n_err++;
        $display("FAIL %s q/r: got %h/%h want %h/%h", dt[k].name, res_q[1][7:0], res_r[1][7:0], dt[k].q, dt[k].r);
      end
      n_vec++;
      if (res_dz[1] !== dt[k].dz || res_ovf[1] !== dt[k].ovf) begin
        n_err++;
        $display("FAIL %s flags: got dz=%b ovf=%b want dz=%b ovf=%b", dt[k].name, res_dz[1], res_ovf[1], dt[k].dz, dt[k].ovf);
      end
      n_vec++;
      if (res_busy_acc[1] !== 1'b1 || res_flag_acc[1] !== 1'b0 || res_busy_done[1] !== 1'b0) begin
        n_err++;
        $display("FAIL %s handshake: got busy@acc=%b flags@acc=%b busy@done=%b want 1 0 0",
                 dt[k].name, res_busy_acc[1], res_flag_acc[1], res_busy_done[1]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int lat   = 0;
    logic [7:0] got_q = 8'd0, got_r = 8'd0;
    drv_sign[1] = 1'b0;
    drv_a[1]    = 13'h0C8;
    drv_b[1]    = 13'h007;
    @(posedge clk);
    @(negedge clk);
    drv_start[1] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      drv_a[1]    = 13'($urandom_range(0, 255));
      drv_b[1]    = 13'($urandom_range(0, 255));
      drv_sign[1] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (mon_done[1]) begin
        dones++;
        lat   = c;
        got_q = mon_q[1][7:0];
        got_r = mon_r[1][7:0];
        break;
      end
    end
    // start still high through the done cycle; it must not be accepted
    @(posedge clk); #1;
    n_vec++;
    if (mon_busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done_cycle: got busy=%b want 0", mon_busy[1]);
    end
    drv_start[1] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (mon_done[1]) dones++;
    end
    n_vec++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL busy_start done_count: got %0d want 1", dones);
    end
    n_vec++;
    if (lat !== 9 || got_q !== 8'h1C || got_r !== 8'h04) begin
      n_err++;
      $display("FAIL busy_start result: got lat=%0d q=%h r=%h want lat=9 q=1c r=04", lat, got_q, got_r);
    end
  endtask

  task automatic test_rst_mid_op();
    int dones = 0;
    drv_sign[1] = 1'b0;
    drv_a[1]    = 13'h0C8;
    drv_b[1]    = 13'h007;
    @(posedge clk);
    @(negedge clk);
    drv_start[1] = 1'b1;
    @(posedge clk); #1;
    drv_start[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({mon_busy[1], mon_done[1], mon_dz[1], mon_ovf[1], mon_q[1], mon_r[1]} !== 30'd0) begin
      n_err++;
      $display("FAIL rst_mid_op outputs: got busy=%b done=%b q=%h r=%h want 0",
               mon_busy[1], mon_done[1], mon_q[1], mon_r[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (mon_done[1] || mon_busy[1]) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL rst_mid_op stray activity: got %0d cycles want 0", dones);
    end
    drv_sign[1] = 1'b1;
    drv_a[1]    = 13'h0F9;
    drv_b[1]    = 13'h002;
    run_ops(3'b010);
    n_vec++;
    if (res_lat[1] !== 9 || res_q[1][7:0] !== 8'hFD || res_r[1][7:0] !== 8'hFF) begin
      n_err++;
      $display("FAIL rst_mid_op next op: got lat=%0d q=%h r=%h want lat=9 q=fd r=ff",
               res_lat[1], res_q[1][7:0], res_r[1][7:0]);
    end
  endtask

  task automatic test_random_back_to_back(input int rounds);
    logic [12:0] eq, er;
    bit          edz, eovf;
    int          w, mask, sel;
    for (int n = 0; n < rounds; n++) begin
      for (int i = 0; i < 3; i++) begin
        w    = width_of(i);
        mask = (1 << w) - 1;
        sel  = $urandom_range(0, 15);
        drv_sign[i] = 1'($urandom_range(0, 1));
        drv_a[i]    = 13'($urandom & mask);
        drv_b[i]    = 13'($urandom & mask);
        if (sel == 0) drv_b[i] = 13'd0;
        if (sel == 1) begin
          drv_sign[i] = 1'b1;
          drv_a[i]    = 13'(1 << (w - 1));
          drv_b[i]    = 13'(mask);
        end
      end
      run_ops(3'b111);
      for (int i = 0; i < 3; i++) begin
        w = width_of(i);
        model(w, drv_sign[i], drv_a[i], drv_b[i], eq, er, edz, eovf);
        n_vec++;
        if (res_seen[i] !== 1'b1 || res_lat[i] !== w + 1) begin
          n_err++;
          $display("FAIL rand w%0d latency: got seen=%b lat=%0d want 1 %0d", w, res_seen[i], res_lat[i], w + 1);
        end
        n_vec++;
        if (res_q[i] !== eq || res_r[i] !== er) begin
          n_err++;
          $display("FAIL rand w%0d s%0b %h/%h q/r: got %h/%h want %h/%h",
                   w, drv_sign[i], drv_a[i], drv_b[i], res_q[i], res_r[i], eq, er);
        end
        n_vec++;
        if (res_dz[i] !== edz || res_ovf[i] !== eovf || res_busy_done[i] !== 1'b0) begin
          n_err++;
          $display("FAIL rand w%0d s%0b %h/%h flags: got dz=%b ovf=%b busy=%b want %b %b 0",
                   w, drv_sign[i], drv_a[i], drv_b[i], res_dz[i], res_ovf[i], res_busy_done[i], edz, eovf);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      drv_start[i] = 1'b0;
      drv_sign[i]  = 1'b0;
      drv_a[i]     = 13'd0;
      drv_b[i]     = 13'd0;
    end
    test_reset();
    test_directed();
    test_start_while_busy();
    test_rst_mid_op();
    test_random_back_to_back(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
